conv_encoder_gen: RTL and testbench

CONV_ENCODER_GEN -- requirements
Module: conv_encoder_gen

---
 rtl/conv_enc_pkg.sv | 57 +++++
 rtl/conv_enc_parity.sv | 17 +
 rtl/conv_encoder_gen.sv | 177 +++++++++++++++++
 tb/tb_conv_encoder_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - shared types, K lookup and generator table for the convolutional encoder
//
// Contents:
//   k_sel_e       - constraint-length select code (00=3, 01=4, 10=5, 11=7)
//   enc_state_e   - encoder frame state (IDLE, RUN, FLUSH)
//   k_of_sel()    - constraint length for a select code
//   GEN_TABLE     - default generator polynomials in octal, one row per K
//   gen_default() - generator lookup by select code and output index
package conv_enc_pkg;

    // Widest generator stored in the default table (K=7).
    localparam int PKG_MAX_K = 7;
    // Width of constraint-length and tail counters; covers K up to 15.
    localparam int K_W       = 4;
    // Generators stored per K row (rate 1/2 uses the first two).
    localparam int N_GEN     = 3;

    typedef enum logic [1:0] {
        K_SEL_3 = 2'b00,
        K_SEL_4 = 2'b01,
        K_SEL_5 = 2'b10,
        K_SEL_7 = 2'b11
    } k_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } enc_state_e;

    // Generator bit K-1 taps the current input bit, bit 0 taps the oldest.
    localparam logic [PKG_MAX_K-1:0] GEN_TABLE [4][N_GEN] = '{
        '{7'o7,   7'o5,   7'o7  },
        '{7'o15,  7'o17,  7'o13 },
        '{7'o23,  7'o35,  7'o25 },
        '{7'o171, 7'o133, 7'o165}
    };

    function automatic logic [K_W-1:0] k_of_sel(input k_sel_e sel);
        case (sel)
            K_SEL_3: return 4'd3;
            K_SEL_4: return 4'd4;
            K_SEL_5: return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

    function automatic logic [PKG_MAX_K-1:0] gen_default(input k_sel_e sel, input logic [1:0] j);
        case (j)
            2'd0:    return GEN_TABLE[sel][0];
            2'd1:    return GEN_TABLE[sel][1];
            2'd2:    return GEN_TABLE[sel][2];
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/conv_enc_parity.sv
// rtl/conv_enc_parity.sv - one coded output bit: XOR-reduce of the register window masked by a generator
//
// Ports:
//   v - register window, v[W-1] is the current input bit, lower bits are older history
//   g - generator polynomial aligned to v
//   p - parity output
module conv_enc_parity #(
    parameter int W = 7
) (
    input  logic [W-1:0] v,
    input  logic [W-1:0] g,
    output logic         p
);

    assign p = ^(v & g);

endmodule

// File: rtl/conv_encoder_gen.sv
// rtl/conv_encoder_gen.sv - rate 1/N_OUT convolutional encoder, selectable K, zero-tail termination
//
// Parameters:
//   N_OUT - coded bits per information bit (2 or 3)
//   MAX_K - longest supported constraint length, sizes the shift register
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   constraint_sel            - K select (00=3, 01=4, 10=5, 11=7), latched at frame start
//   in_valid/in_ready/in_data/in_last     - information bit stream, in_last ends a frame
//   out_valid/out_ready/out_data/out_last - coded symbol stream, out_last on final tail symbol
// Optional feature (macro CONV_ENC_RUNTIME_POLY_EN):
//   poly_we, poly_idx, poly_j, poly_data - write generator table entry [poly_idx][poly_j],
//   honoured only while IDLE; the table resets to the package defaults.
module conv_encoder_gen
    import conv_enc_pkg::*;
#(
    parameter int N_OUT = 2,
    parameter int MAX_K = 7
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CONV_ENC_RUNTIME_POLY_EN
    input  logic             poly_we,
    input  logic [1:0]       poly_idx,
    input  logic [1:0]       poly_j,
    input  logic [MAX_K-1:0] poly_data,
`endif
    input  logic [1:0]       constraint_sel,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    localparam logic [K_W-1:0] K_ONE   = K_W'(1);
    localparam logic [K_W-1:0] K_MAXV  = K_W'(MAX_K);

    enc_state_e       state, state_nxt;
    k_sel_e           k_sel_q;
    k_sel_e           k_sel_eff;
    logic [K_W-1:0]   k_len;
    logic [K_W-1:0]   tail_cnt, tail_cnt_nxt;
    logic [MAX_K-2:0] hist;
    logic [MAX_K-1:0] v;
    logic [MAX_K-1:0] gen [N_OUT];
    logic [N_OUT-1:0] sym;
    logic             out_free;
    logic             in_fire;
    logic             tail_load;
    logic             step;
    logic             step_bit;
    logic             last_tail;

    // The first beat of a frame is encoded with the K being latched on that
    // same edge, so IDLE looks straight through to constraint_sel.
    assign k_sel_eff = (state == IDLE) ? k_sel_e'(constraint_sel) : k_sel_q;
    assign k_len     = k_of_sel(k_sel_eff);

    assign out_free  = !out_valid || out_ready;
    assign in_ready  = rst && (state != FLUSH) && out_free;
    assign in_fire   = in_valid && in_ready;
    assign tail_load = (state == FLUSH) && out_free;
    assign step      = in_fire || tail_load;
    assign step_bit  = (state == FLUSH) ? 1'b0 : in_data;

    // History is kept MSB-aligned (hist[MAX_K-2] = most recent bit), so the
    // K-bit window for any K is simply the top K bits of {bit, hist}.
    assign v = {step_bit, hist} >> (K_MAXV - k_len);

`ifdef CONV_ENC_RUNTIME_POLY_EN
    logic [MAX_K-1:0] gen_q [4][N_GEN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 4; s++) begin
                for (int j = 0; j < N_GEN; j++) begin
                    gen_q[s][j] <= MAX_K'(gen_default(k_sel_e'(s[1:0]), j[1:0]));
                end
            end
        end else if (poly_we && (state == IDLE) && (poly_j != 2'd3)) begin
            gen_q[poly_idx][poly_j] <= poly_data;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_gen_sel
        assign gen[j] = gen_q[k_sel_eff][j];
    end
`else
    for (genvar j = 0; j < N_OUT; j++) begin : g_gen_sel
        assign gen[j] = MAX_K'(gen_default(k_sel_eff, 2'(j)));
    end
`endif

    for (genvar j = 0; j < N_OUT; j++) begin : g_parity
        conv_enc_parity #(
            .W (MAX_K)
        ) u_parity (
            .v (v),
            .g (gen[j]),
            .p (sym[j])
        );
    end

    always_comb begin
        state_nxt    = state;
        tail_cnt_nxt = tail_cnt;
        last_tail    = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (in_fire) begin
                    if (in_last) begin
                        state_nxt    = FLUSH;
                        tail_cnt_nxt = k_len - K_ONE;
                    end else begin
                        state_nxt    = RUN;
                    end
                end
            end
            FLUSH: begin
                if (tail_load) begin
                    if (tail_cnt == K_ONE) begin
                        last_tail    = 1'b1;
                        state_nxt    = IDLE;
                        tail_cnt_nxt = '0;
                    end else begin
                        tail_cnt_nxt = tail_cnt - K_ONE;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                tail_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            k_sel_q  <= K_SEL_3;
            tail_cnt <= '0;
            hist     <= '0;
        end else begin
            state    <= state_nxt;
            tail_cnt <= tail_cnt_nxt;
            if (in_fire && (state == IDLE)) begin
                k_sel_q <= k_sel_e'(constraint_sel);
            end
            // Final tail leaves a clean zero state for the next frame.
            if (step) begin
                hist <= last_tail ? '0 : {step_bit, hist[MAX_K-2:1]};
            end
        end
    end

    // Registered output stage; a new symbol may replace the current one on
    // the same edge it transfers, giving back-to-back throughput.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (step) begin
            out_valid <= 1'b1;
            out_data  <= sym;
            out_last  <= last_tail;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_encoder_gen.sv
// tb/tb_conv_encoder_gen.sv - self-checking bench for conv_encoder_gen (K=3/4/5/7, rate 1/2)
module tb_conv_encoder_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] constraint_sel = 2'b00;
    logic       in_valid = 1'b0;
    logic       in_data  = 1'b0;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
`ifdef CONV_ENC_RUNTIME_POLY_EN
    logic       poly_we   = 1'b0;
    logic [1:0] poly_idx  = 2'd0;
    logic [1:0] poly_j    = 2'd0;
    logic [6:0] poly_data = 7'd0;
`endif

    conv_encoder_gen #(
        .N_OUT (2),
        .MAX_K (7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef CONV_ENC_RUNTIME_POLY_EN
        .poly_we        (poly_we),
        .poly_idx       (poly_idx),
        .poly_j         (poly_j),
        .poly_data      (poly_data),
`endif
        .constraint_sel (constraint_sel),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       beat;
        logic [1:0] sel;
        logic       d;
        logic       last;
        logic [1:0] exp;
        logic       exp_last;
    } vec_t;

    vec_t       tbl[$];
    logic       stim_bits[$];
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic beat, input logic [1:0] sel, input logic d, input logic last,
                       input logic [1:0] exp, input logic exp_last);
        vec_t r;
        r.beat = beat; r.sel = sel; r.d = d; r.last = last; r.exp = exp; r.exp_last = exp_last;
        tbl.push_back(r);
    endtask

    // One step with out_ready high: a beat (or an idle tail slot) then the symbol it produces.
    task automatic apply_vec(input vec_t r, input string tag);
        in_valid = r.beat; in_data = r.d; in_last = r.last; constraint_sel = r.sel; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(r.beat));
        @(posedge clk); #1;
        check({tag, " out"}, {29'd0, out_valid, out_last, out_data}, {29'd0, 1'b1, r.exp_last, r.exp});
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Reference encoder: newest bit at LSB of r, so tap i pairs with generator bit k-1-i.
    task automatic build_model(input int k, input logic [6:0] g0, input logic [6:0] g1);
        int r;
        int n;
        r = 0;
        n = stim_bits.size();
        exp_q.delete();
        for (int t = 0; t < n + k - 1; t++) begin
            int   b;
            logic p0;
            logic p1;
            b  = (t < n) ? int'(stim_bits[t]) : 0;
            p0 = 1'b0;
            p1 = 1'b0;
            r  = ((r << 1) | b) & ((1 << k) - 1);
            for (int i = 0; i < k; i++) begin
                if (r[i]) begin
                    p0 = p0 ^ g0[k-1-i];
                    p1 = p1 ^ g1[k-1-i];
                end
            end
            exp_q.push_back({(t == n + k - 2), p1, p0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        #2;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst out_data", 32'(out_data), 0);
        check("rst out_last", 32'(out_last), 0);
        check("rst in_ready", 32'(in_ready), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("post-rst in_ready", 32'(in_ready), 1);

        // ---- table: back-to-back frames, out_ready high ----
        // K=3: 1,0,1,1 -> 11 01 00 10 | tail 10 11
        add(1, 2'b00, 1, 0, 2'b11, 0);
        add(1, 2'b00, 0, 0, 2'b01, 0);
        add(1, 2'b00, 1, 0, 2'b00, 0);
        add(1, 2'b00, 1, 1, 2'b10, 0);
        add(0, 2'b00, 0, 0, 2'b10, 0);
        add(0, 2'b00, 0, 0, 2'b11, 1);
        // K=7: single 1 -> 11 | tail 01 11 11 00 10 11
        add(1, 2'b11, 1, 1, 2'b11, 0);
        add(0, 2'b11, 0, 0, 2'b01, 0);
        add(0, 2'b11, 0, 0, 2'b11, 0);
        add(0, 2'b11, 0, 0, 2'b11, 0);
        add(0, 2'b11, 0, 0, 2'b00, 0);
        add(0, 2'b11, 0, 0, 2'b10, 0);
        add(0, 2'b11, 0, 0, 2'b11, 1);
        // K=4: 1,1 -> 11 00 | tail 01 01 11
        add(1, 2'b01, 1, 0, 2'b11, 0);
        add(1, 2'b01, 1, 1, 2'b00, 0);
        add(0, 2'b01, 0, 0, 2'b01, 0);
        add(0, 2'b01, 0, 0, 2'b01, 0);
        add(0, 2'b01, 0, 0, 2'b11, 1);
        // K=5: 0,1 -> 00 11 | tail 10 10 01 11
        add(1, 2'b10, 0, 0, 2'b00, 0);
        add(1, 2'b10, 1, 1, 2'b11, 0);
        add(0, 2'b10, 0, 0, 2'b10, 0);
        add(0, 2'b10, 0, 0, 2'b10, 0);
        add(0, 2'b10, 0, 0, 2'b01, 0);
        add(0, 2'b10, 0, 0, 2'b11, 1);
        // select moved 00 -> 11 mid-frame: still K=3, 2 tails
        add(1, 2'b00, 1, 0, 2'b11, 0);
        add(1, 2'b11, 1, 0, 2'b10, 0);
        add(1, 2'b11, 0, 1, 2'b10, 0);
        add(0, 2'b11, 0, 0, 2'b11, 0);
        add(0, 2'b11, 0, 0, 2'b00, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end
        @(posedge clk); #1;
        check("drain out_valid", 32'(out_valid), 0);

        // ---- out_ready stall of 5 cycles mid-frame, K=5 ----
        begin
            int   idx;
            int   got;
            int   cyc;
            int   n;
            logic done;
            logic have_held;
            logic fire_in;
            logic [1:0] held;
            stim_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            build_model(5, 7'o23, 7'o35);
            n = stim_bits.size();
            idx = 0; got = 0; cyc = 0; done = 1'b0; have_held = 1'b0; held = 2'b00;
            constraint_sel = 2'b10;
            while (!done && cyc < 200) begin
                out_ready = !(cyc >= 4 && cyc < 9);
                in_valid  = (idx < n);
                in_data   = (idx < n) ? stim_bits[idx] : 1'b0;
                in_last   = (idx == n - 1);
                #1;
                if (!out_ready && out_valid) begin
                    if (!have_held) begin
                        held = out_data;
                        have_held = 1'b1;
                    end else begin
                        check($sformatf("stall hold c%0d", cyc), 32'(out_data), 32'(held));
                    end
                    check($sformatf("stall in_ready c%0d", cyc), 32'(in_ready), 0);
                end
                if (out_valid && out_ready) begin
                    if (got < exp_q.size()) begin
                        check($sformatf("stall sym%0d", got), {29'd0, out_last, out_data}, {29'd0, exp_q[got]});
                    end else begin
                        check("stall extra symbol", got, exp_q.size() - 1);
                    end
                    got++;
                    if (out_last) done = 1'b1;
                end
                fire_in = in_valid && in_ready;
                @(posedge clk); #1;
                if (fire_in) idx++;
                cyc++;
            end
            in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
            check("stall symbol count", got, exp_q.size());
            check("stall bits consumed", idx, n);
            check("stall hold seen", 32'(have_held), 1);
        end

        // ---- reset asserted during FLUSH, then a fresh K=3 frame ----
        @(posedge clk); #1;
        constraint_sel = 2'b11; in_valid = 1'b1; in_data = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        check("flush in_ready", 32'(in_ready), 0);
        check("flush out_valid", 32'(out_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 0);
        check("async rst in_ready", 32'(in_ready), 0);
        check("async rst out_last", 32'(out_last), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tbl.delete();
        add(1, 2'b00, 1, 1, 2'b11, 0);
        add(0, 2'b00, 0, 0, 2'b01, 0);
        add(0, 2'b00, 0, 0, 2'b11, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], $sformatf("after-rst%0d", i));
        end

`ifdef CONV_ENC_RUNTIME_POLY_EN
        // ---- runtime generator: K=3 G0 := 3 ----
        @(posedge clk); #1;
        poly_we = 1'b1; poly_idx = 2'd0; poly_j = 2'd0; poly_data = 7'o3;
        @(posedge clk); #1;
        poly_we = 1'b0;
        tbl.delete();
        add(1, 2'b00, 1, 1, 2'b10, 0);
        add(0, 2'b00, 0, 0, 2'b01, 0);
        add(0, 2'b00, 0, 0, 2'b11, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], $sformatf("poly%0d", i));
        end
`endif

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
